// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - sequences one signed multiply job through an external Booth multiplier
// Handshakes an operand pair in, drives clear/start, waits with a timeout, and holds the product until taken.
module mul_sequencer #(
    parameter int TIMEOUT = 256,
    parameter int W       = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_product,
    output logic           err_timeout,
    output logic           busy,
    output logic [W-1:0]   mul_multiplier,
    output logic [W-1:0]   mul_multiplicand,
    output logic           mul_op_start,
    output logic           mul_op_clear,
    input  logic           mul_op_done,
    input  logic [2*W-1:0] mul_result
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;

    // reset_n is active-high despite its name
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        prod_d       = prod_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        mul_op_start = 1'b0;
        mul_op_clear = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    err_d   = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                mul_op_clear = 1'b1;
                state_d      = S_START;
            end
            S_START: begin
                mul_op_start = 1'b1;
                cnt_d        = '0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                // completion takes priority over a coincident timeout
                if (mul_op_done) begin
                    prod_d  = mul_result;
                    state_d = S_HOLD;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d        = 1'b1;
                    mul_op_clear = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // while reset is held the multiplier is kept cleared and no handshakes occur
        if (reset_n) begin
            in_ready     = 1'b0;
            out_valid    = 1'b0;
            mul_op_start = 1'b0;
            mul_op_clear = 1'b1;
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign err_timeout      = err_q;
    assign out_product      = prod_q;
    assign mul_multiplier   = a_q;
    assign mul_multiplicand = b_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - randomized self-checking bench for mul_sequencer
// A behavioural multiplier with programmable latency feeds the DUT; products come from plain signed arithmetic.
module tb_mul_sequencer;

    localparam int W       = 64;
    localparam int TIMEOUT = 256;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2*W-1:0]   out_product;
    logic             err_timeout;
    logic             busy;
    logic [W-1:0]     mul_multiplier;
    logic [W-1:0]     mul_multiplicand;
    logic             mul_op_start;
    logic             mul_op_clear;
    logic             mul_op_done;
    logic [2*W-1:0]   mul_result;

    mul_sequencer #(.TIMEOUT(TIMEOUT), .W(W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .err_timeout      (err_timeout),
        .busy             (busy),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_op_start     (mul_op_start),
        .mul_op_clear     (mul_op_clear),
        .mul_op_done      (mul_op_done),
        .mul_result       (mul_result)
    );

    always #5 clk = ~clk;

    // multiplier model: done pulses 'lat_cfg' cycles after the start cycle; clear cancels
    int             lat_cfg = 10;
    bit             never_done = 1'b0;
    logic           stray_done = 1'b0;
    logic           pend = 1'b0;
    int             mcnt = 0;
    logic [127:0]   mres = '0;
    int             cyc = 0;
    int             start_cyc = 0;
    int             clear_cyc = 0;
    int             clear_cnt = 0;

    wire model_fire = pend && (mcnt == 0) && !never_done;
    assign mul_op_done = model_fire | stray_done;
    assign mul_result  = model_fire ? mres : ~mres;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mul_op_start) start_cyc <= cyc;
        if (mul_op_clear) begin
            clear_cyc <= cyc;
            clear_cnt <= clear_cnt + 1;
        end
        if (mul_op_clear) begin
            pend <= 1'b0;
        end else if (mul_op_start) begin
            pend <= 1'b1;
            mcnt <= lat_cfg - 1;
            mres <= $signed(mul_multiplier) * $signed(mul_multiplicand);
        end else if (pend) begin
            if (mcnt == 0) pend <= 1'b0;
            else mcnt <= mcnt - 1;
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic run_job(input logic [63:0] a, input logic [63:0] b, input int lat, input int stall);
        logic signed [63:0]  sa;
        logic signed [127:0] e;
        int t0;
        int bad;
        bit got;
        sa = a;
        e  = sa * $signed(b);
        lat_cfg    = lat;
        never_done = 1'b0;
        check("ready_before_job", 128'(in_ready), 128'(1));
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk); #1;
            if (out_valid) got = 1'b1;
        end
        check("latency", 128'(cyc - t0), 128'(2 + lat));
        check("product", out_product, e);
        check("err_clean", 128'(err_timeout), 128'(0));
        check("clear_to_start", 128'(start_cyc - clear_cyc), 128'(1));
        bad = 0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (!out_valid || out_product !== e || in_ready) bad++;
        end
        if (stall > 0) check("stall_hold", 128'(bad), 128'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_idle", 128'({busy, in_ready, out_valid}), 128'(3'b010));
    endtask

    task automatic run_timeout(input int lat, input bit never);
        int t0;
        int c0;
        int ov;
        bit got;
        lat_cfg    = lat;
        never_done = never;
        in_a = 64'd11;
        in_b = 64'd13;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t0 = cyc;
        c0 = clear_cnt;
        ov = 0;
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov++;
            if (err_timeout) got = 1'b1;
        end
        check("timeout_cycles", 128'(cyc - t0), 128'(2 + TIMEOUT));
        check("timeout_clears", 128'(clear_cnt - c0), 128'(2));
        check("timeout_no_out", 128'(ov), 128'(0));
        check("timeout_ready", 128'({in_ready, busy}), 128'(2'b10));
        never_done = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 128'({in_ready, out_valid, mul_op_start, mul_op_clear, busy, err_timeout}), 128'(6'b000100));
        #2 reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst_release_ready", 128'({in_ready, busy}), 128'(2'b10));
        check("rst_product", out_product, 128'(0));

        run_job(64'd3, 64'd5, 66, 0);
        run_job(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 100, 0);
        run_job(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 130, 0);
        run_job(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 70, 20);
        run_job(64'd0, 64'd0, 1, 0);
        run_job(64'd9, 64'hFFFF_FFFF_FFFF_FFFE, TIMEOUT, 0);

        run_timeout(0, 1'b1);
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        check("stray_done_ignored", 128'({busy, out_valid, err_timeout}), 128'(3'b001));
        run_timeout(TIMEOUT + 1, 1'b0);

        for (int j = 0; j < 12; j++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (j % 4 == 1) ra = 64'($signed(32'($urandom_range(0, 200)) - 32'sd100));
            run_job(ra, rb, $urandom_range(1, 130), $urandom_range(0, 3));
        end

        lat_cfg = 100;
        in_a = 64'd77;
        in_b = 64'd88;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        check("midwait_rst_outputs", 128'({in_ready, out_valid, mul_op_start, mul_op_clear, busy, err_timeout}), 128'(6'b000100));
        check("midwait_rst_operand", 128'({mul_multiplier, mul_multiplicand}), 128'(0));
        @(posedge clk);
        #3 reset_n = 1'b0;
        @(posedge clk); #1;
        check("midwait_release_ready", 128'(in_ready), 128'(1));
        run_job(64'd2, 64'd2, 80, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
